imem_fetch_ctrl: RTL and testbench
==================================

// Module: imem_fetch_ctrl
// PURPOSE
//   Sequences and arbitrates the single-port 256x32 instruction memory between the boot program
//   loader (writes) and the core fetch stage (reads). Sits between IF stage and the IMEM array.
//   Owns boot gating, PC-to-word translation, alignment/range checking and fetch handshake.
//   Memory read latency is one clock (synchronous read).
// PARAMETERS
//   INST_WIDTH_LENGTH  32      instruction / memory word width
//   PC_WIDTH_LENGTH    32      PC and loader byte-address width
//   MEM_DEPTH          256     words in IMEM; word index = PC[9:2] at default
//   ADDR_W             8       log2(MEM_DEPTH)
// PORTS
//   clk         in   1                  single clock, all logic on rising edge
//   rst_n       in   1                  synchronous, active-low reset
//   boot_done   in   1                  loader finished; level, sampled each cycle
//   ld_valid    in   1                  loader write request
//   ld_addr     in   PC_WIDTH_LENGTH    loader byte address
//   ld_data     in   INST_WIDTH_LENGTH  loader write data
//   ld_ready    out  1                  write accepted this cycle
//   fetch_req   in   1                  IF requests instruction at PC
//   PC          in   PC_WIDTH_LENGTH    fetch byte address, held stable while fetch_req && !fetch_valid
//   fetch_ready in   1                  IF consumes inst
//   fetch_valid out  1                  inst valid
//   inst        out  INST_WIDTH_LENGTH  fetched instruction
//   fetch_err   out  2                  with fetch_valid: 00 ok, 01 misaligned, 10 out of range
//   mem_en      out  1                  memory port enable
//   mem_we      out  1                  memory write enable
//   mem_addr    out  ADDR_W             memory word address
//   mem_wdata   out  INST_WIDTH_LENGTH  memory write data
//   mem_rdata   in   INST_WIDTH_LENGTH  memory read data, valid cycle after mem_en && !mem_we
// BEHAVIOUR
//   Reset (rst_n=0 at edge): state=BOOT; fetch_valid=0, inst=0, fetch_err=00, ld_ready=0, mem_en=0,
//     mem_we=0, mem_addr=0, mem_wdata=0. Reset mid-read discards the read; no response issued.
//   States: BOOT, IDLE, READ, RESP.
//   BOOT: fetch_req ignored. ld_valid -> ld_ready=1 same cycle (comb), mem write issued; ld_addr[1:0]!=0
//     or ld_addr beyond MEM_DEPTH*4 -> ld_ready=1, write suppressed (dropped). boot_done=1 -> IDLE.
//   IDLE: priority loader > fetch. ld_valid: accept write as in BOOT, fetch waits. Else fetch_req:
//     misaligned (PC[1:0]!=0) -> RESP, inst=0, fetch_err=01, no memory access;
//     out of range (PC[31:10]!=0 at default) -> RESP, inst=0, fetch_err=10;
//     else mem_en=1, mem_addr=PC[9:2] -> READ.
//   READ: capture mem_rdata into inst, fetch_err=00 -> RESP. Loader stalled (ld_ready=0).
//   RESP: fetch_valid=1, inst/fetch_err held until fetch_ready; on fetch_ready -> IDLE (fetch_valid=0
//     next cycle). Loader stalled. Min fetch latency: req cycle N -> fetch_valid in N+2.
//   Write then read of same address in consecutive grants returns new data (write lands first).
//   boot_done deasserting after IDLE has no effect; only reset returns to BOOT.
//   inst never driven to high-Z; error responses return 0.
//   mem_en/mem_we are single-cycle pulses; mem_we=1 implies mem_en=1.
// STRUCTURE
//   Shared package imem_pkg: state encoding (BOOT/IDLE/READ/RESP), fetch_err codes FE_OK/FE_MISALIGN/
//     FE_RANGE, INST_WIDTH_LENGTH/MEM_DEPTH defaults.
//   One sub-module: imem_addr_chk (comb) -> word index, misaligned flag, range flag; instanced twice
//     (PC, ld_addr). FSM and output registers in top.
// TESTING
//   Boot load: ld_addr 0x0,0x4,0x8 data 0xA,0xB,0xC, fetch_req held -> 3 writes to words 0-2, no fetch_valid
//     until boot_done=1; then PC=0x4 -> inst=0xB, fetch_err=00, fetch_valid 2 cycles after req.
//   Misaligned: PC=0x6 -> fetch_valid next RESP, inst=0, fetch_err=01, mem_en never asserted.
//   Range: PC=0x400 -> inst=0, fetch_err=10; PC=0x3FC -> word 255 returned.
//   Contention: ld_valid and fetch_req same IDLE cycle -> write wins, fetch granted next cycle,
//     write 0x1234 to 0x10 then fetch 0x10 returns 0x1234.
//   Backpressure: fetch_ready=0 for 5 cycles -> inst/fetch_valid stable, ld_ready=0 throughout.
//   Reset mid-READ: rst_n=0 -> all outputs 0, state BOOT, fetch ignored until boot_done.

Source files
------------

// File: rtl/imem_fetch_ctrl_pkg.sv
// Shared types and defaults for the instruction-memory fetch controller.
// Pure declarations: no latency, no flow control.
package imem_fetch_ctrl_pkg;

    localparam int DEF_INST_WIDTH_LENGTH = 32;
    localparam int DEF_PC_WIDTH_LENGTH   = 32;
    localparam int DEF_MEM_DEPTH         = 256;
    localparam int DEF_ADDR_W            = $clog2(DEF_MEM_DEPTH);

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_IDLE = 2'd1,
        ST_READ = 2'd2,
        ST_RESP = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        FE_OK       = 2'b00,
        FE_MISALIGN = 2'b01,
        FE_RANGE    = 2'b10
    } fetch_err_e;

endpackage

// File: rtl/imem_fetch_ctrl_if.sv
// Loader, fetch and memory-port signals of the fetch controller; slave = controller side.
// Wires only: no latency; loader uses valid/ready, fetch uses req/valid/ready.
interface imem_fetch_ctrl_if
    import imem_fetch_ctrl_pkg::*;
#(
    parameter int INST_W = DEF_INST_WIDTH_LENGTH,
    parameter int PC_W   = DEF_PC_WIDTH_LENGTH,
    parameter int ADDR_W = DEF_ADDR_W
);
    logic              boot_done;
    logic              ld_valid;
    logic [PC_W-1:0]   ld_addr;
    logic [INST_W-1:0] ld_data;
    logic              ld_ready;
    logic              fetch_req;
    logic [PC_W-1:0]   PC;
    logic              fetch_ready;
    logic              fetch_valid;
    logic [INST_W-1:0] inst;
    logic [1:0]        fetch_err;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [INST_W-1:0] mem_wdata;
    logic [INST_W-1:0] mem_rdata;

    modport slave (
        input  boot_done, ld_valid, ld_addr, ld_data, fetch_req, PC, fetch_ready, mem_rdata,
        output ld_ready, fetch_valid, inst, fetch_err, mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output boot_done, ld_valid, ld_addr, ld_data, fetch_req, PC, fetch_ready, mem_rdata,
        input  ld_ready, fetch_valid, inst, fetch_err, mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/imem_fetch_ctrl_addr_chk.sv
// Byte address -> word index plus misalignment and out-of-range flags.
// Combinational, no flow control.
module imem_fetch_ctrl_addr_chk #(
    parameter int PC_W   = 32,
    parameter int ADDR_W = 8
) (
    input  logic [PC_W-1:0]   addr_i,
    output logic [ADDR_W-1:0] idx_o,
    output logic              misalign_o,
    output logic              range_o
);
    assign idx_o      = addr_i[ADDR_W+1:2];
    assign misalign_o = |addr_i[1:0];
    assign range_o    = |addr_i[PC_W-1:ADDR_W+2];
endmodule

// File: rtl/imem_fetch_ctrl.sv
// Arbitrates the single-port IMEM between boot loader writes and IF fetches; fetch ok in 2 cycles, errors in 1.
// Loader wins in IDLE and is stalled while a fetch is in READ/RESP; RESP holds until fetch_ready.
module imem_fetch_ctrl
    import imem_fetch_ctrl_pkg::*;
#(
    parameter int INST_WIDTH_LENGTH = DEF_INST_WIDTH_LENGTH,
    parameter int PC_WIDTH_LENGTH   = DEF_PC_WIDTH_LENGTH,
    parameter int MEM_DEPTH         = DEF_MEM_DEPTH
) (
    input logic               clk,
    input logic               rst_n,
    imem_fetch_ctrl_if.slave  bus
);
    localparam int ADDR_W = $clog2(MEM_DEPTH);

    state_e                       state_q, state_d;
    logic [INST_WIDTH_LENGTH-1:0] inst_q, inst_d;
    fetch_err_e                   err_q, err_d;

    logic [ADDR_W-1:0]            pc_idx, ld_idx;
    logic                         pc_mis, pc_rng, ld_mis, ld_rng;

    logic                         ld_ready;
    logic                         mem_en;
    logic                         mem_we;
    logic [ADDR_W-1:0]            mem_addr;
    logic [INST_WIDTH_LENGTH-1:0] mem_wdata;

    imem_fetch_ctrl_addr_chk #(.PC_W(PC_WIDTH_LENGTH), .ADDR_W(ADDR_W)) u_pc_chk (
        .addr_i     (bus.PC),
        .idx_o      (pc_idx),
        .misalign_o (pc_mis),
        .range_o    (pc_rng)
    );

    imem_fetch_ctrl_addr_chk #(.PC_W(PC_WIDTH_LENGTH), .ADDR_W(ADDR_W)) u_ld_chk (
        .addr_i     (bus.ld_addr),
        .idx_o      (ld_idx),
        .misalign_o (ld_mis),
        .range_o    (ld_rng)
    );

    always_comb begin
        state_d   = state_q;
        inst_d    = inst_q;
        err_d     = err_q;
        ld_ready  = 1'b0;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        // Port strobes stay quiet while reset is held so nothing lands in memory.
        if (rst_n) begin
            case (state_q)
                ST_BOOT, ST_IDLE: begin
                    if (bus.ld_valid) begin
                        ld_ready = 1'b1;
                        if (!ld_mis && !ld_rng) begin
                            mem_en    = 1'b1;
                            mem_we    = 1'b1;
                            mem_addr  = ld_idx;
                            mem_wdata = bus.ld_data;
                        end
                    end else if (state_q == ST_IDLE && bus.fetch_req) begin
                        if (pc_mis) begin
                            inst_d  = '0;
                            err_d   = FE_MISALIGN;
                            state_d = ST_RESP;
                        end else if (pc_rng) begin
                            inst_d  = '0;
                            err_d   = FE_RANGE;
                            state_d = ST_RESP;
                        end else begin
                            mem_en   = 1'b1;
                            mem_addr = pc_idx;
                            state_d  = ST_READ;
                        end
                    end
                    if (state_q == ST_BOOT && bus.boot_done) begin
                        state_d = ST_IDLE;
                    end
                end
                ST_READ: begin
                    inst_d  = bus.mem_rdata;
                    err_d   = FE_OK;
                    state_d = ST_RESP;
                end
                ST_RESP: begin
                    if (bus.fetch_ready) begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_BOOT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_BOOT;
            inst_q  <= '0;
            err_q   <= FE_OK;
        end else begin
            state_q <= state_d;
            inst_q  <= inst_d;
            err_q   <= err_d;
        end
    end

    assign bus.ld_ready    = ld_ready;
    assign bus.fetch_valid = (state_q == ST_RESP);
    assign bus.inst        = inst_q;
    assign bus.fetch_err   = err_q;
    assign bus.mem_en      = mem_en;
    assign bus.mem_we      = mem_we;
    assign bus.mem_addr    = mem_addr;
    assign bus.mem_wdata   = mem_wdata;
endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Directed plus randomized bench for imem_fetch_ctrl with a 256x32 synchronous-read memory attached.
// Expected responses come from a word-array model updated by every accepted, legal loader write.
module tb_imem_fetch_ctrl;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    imem_fetch_ctrl_if bus ();

    imem_fetch_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [31:0] mem     [256];
    logic [31:0] ref_mem [256];
    int          checks     = 0;
    int          failures   = 0;
    int          mem_en_cnt = 0;
    logic [31:0] ra;

    always @(posedge clk) begin
        if (bus.mem_en) begin
            mem_en_cnt <= mem_en_cnt + 1;
            if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
            else            bus.mem_rdata     <= mem[bus.mem_addr];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_fetch_valid"}, bus.fetch_valid, 0);
        chk({tag, "_inst"},        bus.inst, 0);
        chk({tag, "_fetch_err"},   bus.fetch_err, 0);
        chk({tag, "_ld_ready"},    bus.ld_ready, 0);
        chk({tag, "_mem_en"},      bus.mem_en, 0);
        chk({tag, "_mem_we"},      bus.mem_we, 0);
        chk({tag, "_mem_addr"},    bus.mem_addr, 0);
        chk({tag, "_mem_wdata"},   bus.mem_wdata, 0);
    endtask

    task automatic do_load(input logic [31:0] a, input logic [31:0] d);
        bit ok;
        ok = (a % 4 == 0) && (a < 1024);
        bus.ld_valid = 1'b1;
        bus.ld_addr  = a;
        bus.ld_data  = d;
        #1;
        chk("ld_ready", bus.ld_ready, 1);
        chk("ld_write", bus.mem_we, ok);
        if (ok) begin
            chk("ld_waddr", bus.mem_addr, a / 4);
            chk("ld_wdata", bus.mem_wdata, d);
            ref_mem[a / 4] = d;
        end
        @(negedge clk);
        bus.ld_valid = 1'b0;
        #1;
    endtask

    task automatic do_fetch(input logic [31:0] a, input int hold);
        logic [31:0] exp_inst;
        logic [1:0]  exp_err;
        int          exp_lat;
        int          lat;
        int          en0;
        if (a % 4 != 0) begin
            exp_inst = 0; exp_err = 2'b01; exp_lat = 1;
        end else if (a >= 1024) begin
            exp_inst = 0; exp_err = 2'b10; exp_lat = 1;
        end else begin
            exp_inst = ref_mem[a / 4]; exp_err = 2'b00; exp_lat = 2;
        end
        en0 = mem_en_cnt;
        bus.fetch_req   = 1'b1;
        bus.PC          = a;
        bus.fetch_ready = 1'b0;
        #1;
        chk("rd_en", bus.mem_en, exp_err == 2'b00);
        chk("rd_we", bus.mem_we, 0);
        if (exp_err == 2'b00) chk("rd_addr", bus.mem_addr, a / 4);
        lat = 0;
        for (int i = 1; i <= 4 && lat == 0; i++) begin
            @(negedge clk);
            #1;
            if (bus.fetch_valid) lat = i;
        end
        chk("fetch_latency", lat, exp_lat);
        chk("fetch_inst", bus.inst, exp_inst);
        chk("fetch_err", bus.fetch_err, exp_err);
        chk("mem_access_count", mem_en_cnt - en0, (exp_err == 2'b00) ? 1 : 0);
        for (int i = 0; i < hold; i++) begin
            bus.ld_valid = 1'b1;
            bus.ld_addr  = 32'h0;
            bus.ld_data  = 32'hDEAD_BEEF;
            #1;
            chk("stall_ld_ready", bus.ld_ready, 0);
            chk("stall_mem_en", bus.mem_en, 0);
            @(negedge clk);
            #1;
            chk("stall_valid", bus.fetch_valid, 1);
            chk("stall_inst", bus.inst, exp_inst);
            chk("stall_err", bus.fetch_err, exp_err);
        end
        bus.ld_valid    = 1'b0;
        bus.fetch_req   = 1'b0;
        bus.fetch_ready = 1'b1;
        @(negedge clk);
        bus.fetch_ready = 1'b0;
        #1;
        chk("valid_drop", bus.fetch_valid, 0);
    endtask

    function automatic logic [31:0] gen_addr();
        int unsigned sel;
        sel = $urandom_range(0, 5);
        if (sel <= 3)      return $urandom_range(0, 255) * 4;
        else if (sel == 4) return $urandom_range(0, 255) * 4 + $urandom_range(1, 3);
        else               return ($urandom | 32'h0000_0400) & 32'hFFFF_FFFC;
    endfunction

    initial begin
        rst_n           = 1'b0;
        bus.boot_done   = 1'b0;
        bus.ld_valid    = 1'b0;
        bus.ld_addr     = '0;
        bus.ld_data     = '0;
        bus.fetch_req   = 1'b0;
        bus.PC          = '0;
        bus.fetch_ready = 1'b0;
        bus.mem_rdata   = '0;
        for (int w = 0; w < 256; w++) ref_mem[w] = 32'h0;

        repeat (2) @(negedge clk);
        #1;
        chk_idle_outputs("reset");
        rst_n = 1'b1;

        // Boot: fetch_req is held high and must be ignored until boot_done.
        bus.fetch_req = 1'b1;
        bus.PC        = 32'h4;
        do_load(32'h0, 32'hA);
        do_load(32'h4, 32'hB);
        do_load(32'h8, 32'hC);
        chk("boot_fetch_ignored_en", bus.mem_en, 0);
        chk("boot_fetch_ignored_valid", bus.fetch_valid, 0);
        do_load(32'h6, 32'h5555_5555);
        do_load(32'h400, 32'h6666_6666);
        for (int w = 3; w < 256; w++) do_load(w * 4, $urandom);
        chk("boot_no_valid", bus.fetch_valid, 0);
        bus.fetch_req = 1'b0;
        bus.boot_done = 1'b1;
        @(negedge clk);
        bus.boot_done = 1'b0;
        #1;

        do_fetch(32'h4, 0);
        do_fetch(32'h6, 0);
        do_fetch(32'h400, 0);
        do_load(32'h3FC, 32'hCAFE_F00D);
        do_fetch(32'h3FC, 0);

        // Same-cycle contention: the write must win and the fetch must see it.
        bus.ld_valid  = 1'b1;
        bus.ld_addr   = 32'h10;
        bus.ld_data   = 32'h1234;
        bus.fetch_req = 1'b1;
        bus.PC        = 32'h10;
        #1;
        chk("cont_ld_ready", bus.ld_ready, 1);
        chk("cont_we", bus.mem_we, 1);
        chk("cont_addr", bus.mem_addr, 32'h4);
        ref_mem[4] = 32'h1234;
        @(negedge clk);
        bus.ld_valid = 1'b0;
        do_fetch(32'h10, 0);

        do_fetch(32'h8, 5);

        // Reset while a read is outstanding.
        bus.fetch_req = 1'b1;
        bus.PC        = 32'h8;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        #1;
        chk_idle_outputs("rst_read");
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            chk("rst_boot_valid", bus.fetch_valid, 0);
            chk("rst_boot_en", bus.mem_en, 0);
        end
        bus.fetch_req = 1'b0;
        bus.boot_done = 1'b1;
        @(negedge clk);
        bus.boot_done = 1'b0;
        #1;
        do_fetch(32'h8, 1);

        for (int n = 0; n < 120; n++) begin
            ra = gen_addr();
            if ($urandom_range(0, 2) == 0) do_load(ra, $urandom);
            else                           do_fetch(ra, $urandom_range(0, 3));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
